// File: rtl/bw_clk_cclk_scanchain_nx_if.sv
// Scan/config bundle for the clock-cluster scan chain.
// master: the scan controller side that drives strobes and serial data.
// slave:  the scan chain itself.
interface bw_clk_cclk_scanchain_nx_if #(
    parameter int WIDTH = 8
);
    logic             se;
    logic             sd;
    logic             cap;
    logic [WIDTH-1:0] pd;
    logic             upd;
    logic             so;
    logic [WIDTH-1:0] q;
    logic             full;
    logic             err;

    modport master (
        output se, sd, cap, pd, upd,
        input  so, q, full, err
    );

    modport slave (
        input  se, sd, cap, pd, upd,
        output so, q, full, err
    );
endinterface

// File: rtl/bw_clk_cclk_scanchain_nx.sv
// Clock-cluster configuration scan chain.
// A WIDTH-bit shift chain (serial in, parallel capture) feeds a guarded
// update register q.  q is only loaded when exactly WIDTH bits have been
// shifted in since the last capture/update, so downstream clock logic never
// sees a partially loaded word.  An update attempted early sets a sticky err.
// The serial output can be retimed through a falling-edge lock-up stage so
// the next segment, clocked on the same edge, sees a half-cycle of hold.
module bw_clk_cclk_scanchain_nx #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               LOCKUP    = 1
) (
    input  logic                             ck,
    input  logic                             rst,
    bw_clk_cclk_scanchain_nx_if.slave        bus
);

    localparam int             CNT_W   = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [WIDTH-1:0] chain_reg, chain_next;
    logic [WIDTH-1:0] chain_shifted;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [WIDTH-1:0] q_reg, q_next;
    logic             err_reg, err_next;
    logic             full;

    // Shifted view of the chain: bit 0 takes sd, every other bit takes its
    // lower neighbour.
    assign chain_shifted[0] = bus.sd;
    generate
        for (genvar gi = 1; gi < WIDTH; gi++) begin : g_shift
            assign chain_shifted[gi] = chain_reg[gi-1];
        end
    endgenerate

    // The counter saturates at WIDTH, so full stays up during over-shifting.
    assign full = (cnt_reg == CNT_MAX);

    // Next-state decode: shift beats capture; a qualified update snapshots
    // the pre-edge chain and restarts the bit count (counting this cycle's
    // shift, if any).
    always_comb begin
        chain_next = chain_reg;
        cnt_next   = cnt_reg;
        q_next     = q_reg;
        err_next   = err_reg;

        if (bus.se) begin
            chain_next = chain_shifted;
            cnt_next   = full ? cnt_reg : (cnt_reg + CNT_ONE);
        end else if (bus.cap) begin
            chain_next = bus.pd;
            cnt_next   = '0;
        end

        if (bus.upd) begin
            if (full) begin
                q_next   = chain_reg;
                cnt_next = bus.se ? CNT_ONE : '0;
            end else begin
                err_next = 1'b1;
            end
        end
    end

    // Rising-edge state with asynchronous reset to the documented values.
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            chain_reg <= '0;
            cnt_reg   <= '0;
            q_reg     <= RESET_VAL;
            err_reg   <= 1'b0;
        end else begin
            chain_reg <= chain_next;
            cnt_reg   <= cnt_next;
            q_reg     <= q_next;
            err_reg   <= err_next;
        end
    end

    assign bus.q    = q_reg;
    assign bus.full = full;
    assign bus.err  = err_reg;

    generate
        if (LOCKUP != 0) begin : g_lockup
            logic lockup_reg;

            // Falling-edge lock-up: presents the chain MSB half a cycle late.
            always_ff @(negedge ck or posedge rst) begin
                if (rst) begin
                    lockup_reg <= 1'b0;
                end else begin
                    lockup_reg <= chain_reg[WIDTH-1];
                end
            end

            assign bus.so = lockup_reg;
        end else begin : g_direct
            assign bus.so = chain_reg[WIDTH-1];
        end
    endgenerate

endmodule

// File: tb/tb_bw_clk_cclk_scanchain_nx.sv
// Bench for bw_clk_cclk_scanchain_nx: a lock-up and a direct-output instance
// are driven with identical stimulus and checked against a word-level model.
module tb_bw_clk_cclk_scanchain_nx;

    localparam int           W  = 4;
    localparam logic [W-1:0] RV = 4'hA;

    logic ck;
    logic rst;

    bw_clk_cclk_scanchain_nx_if #(.WIDTH(W)) bus_l ();
    bw_clk_cclk_scanchain_nx_if #(.WIDTH(W)) bus_d ();

    bw_clk_cclk_scanchain_nx #(.WIDTH(W), .RESET_VAL(RV), .LOCKUP(1)) dut_l (
        .ck  (ck),
        .rst (rst),
        .bus (bus_l)
    );

    bw_clk_cclk_scanchain_nx #(.WIDTH(W), .RESET_VAL(RV), .LOCKUP(0)) dut_d (
        .ck  (ck),
        .rst (rst),
        .bus (bus_d)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    int num_checks = 0;
    int num_errors = 0;

    // Reference model state
    logic [W-1:0] m_chain;
    int           m_cnt;
    logic [W-1:0] m_q;
    logic         m_err;
    logic         m_lock;

    task automatic drive(input logic se_i, input logic sd_i, input logic cap_i,
                         input logic [W-1:0] pd_i, input logic upd_i);
        bus_l.se = se_i; bus_l.sd = sd_i; bus_l.cap = cap_i; bus_l.pd = pd_i; bus_l.upd = upd_i;
        bus_d.se = se_i; bus_d.sd = sd_i; bus_d.cap = cap_i; bus_d.pd = pd_i; bus_d.upd = upd_i;
    endtask

    task automatic model_reset();
        m_chain = '0;
        m_cnt   = 0;
        m_q     = RV;
        m_err   = 1'b0;
        m_lock  = 1'b0;
    endtask

    // One clock cycle: apply inputs, check after the rising edge and again
    // after the following falling edge (where the lock-up output moves).
    task automatic step(input logic se_i, input logic sd_i, input logic cap_i,
                        input logic [W-1:0] pd_i, input logic upd_i);
        logic [W-1:0] oc;
        bit           ofull;
        drive(se_i, sd_i, cap_i, pd_i, upd_i);
        @(posedge ck);
        oc    = m_chain;
        ofull = (m_cnt == W);
        if (se_i) begin
            m_chain = W'((oc << 1) | W'(sd_i));
            m_cnt   = (m_cnt + 1 > W) ? W : m_cnt + 1;
        end else if (cap_i) begin
            m_chain = pd_i;
            m_cnt   = 0;
        end
        if (upd_i) begin
            if (ofull) begin
                m_q   = oc;
                m_cnt = se_i ? 1 : 0;
            end else begin
                m_err = 1'b1;
            end
        end
        #1;
        $display("%0t se=%0b sd=%0b cap=%0b pd=%h upd=%0b | q=%h/%h full=%0b/%0b err=%0b/%0b so_d=%0b so_l=%0b",
                 $time, se_i, sd_i, cap_i, pd_i, upd_i, bus_l.q, bus_d.q,
                 bus_l.full, bus_d.full, bus_l.err, bus_d.err, bus_d.so, bus_l.so);
        num_checks++;
        if (bus_l.q !== m_q) begin
            num_errors++; $display("FAIL q_lockup: got %h expected %h", bus_l.q, m_q);
        end
        num_checks++;
        if (bus_d.q !== m_q) begin
            num_errors++; $display("FAIL q_direct: got %h expected %h", bus_d.q, m_q);
        end
        num_checks++;
        if (bus_l.full !== (m_cnt == W)) begin
            num_errors++; $display("FAIL full_lockup: got %0b expected %0b", bus_l.full, (m_cnt == W));
        end
        num_checks++;
        if (bus_d.full !== (m_cnt == W)) begin
            num_errors++; $display("FAIL full_direct: got %0b expected %0b", bus_d.full, (m_cnt == W));
        end
        num_checks++;
        if (bus_l.err !== m_err) begin
            num_errors++; $display("FAIL err_lockup: got %0b expected %0b", bus_l.err, m_err);
        end
        num_checks++;
        if (bus_d.err !== m_err) begin
            num_errors++; $display("FAIL err_direct: got %0b expected %0b", bus_d.err, m_err);
        end
        num_checks++;
        if (bus_d.so !== m_chain[W-1]) begin
            num_errors++; $display("FAIL so_direct: got %0b expected %0b", bus_d.so, m_chain[W-1]);
        end
        num_checks++;
        if (bus_l.so !== m_lock) begin
            num_errors++; $display("FAIL so_lockup_before_negedge: got %0b expected %0b", bus_l.so, m_lock);
        end
        @(negedge ck);
        m_lock = m_chain[W-1];
        #1;
        num_checks++;
        if (bus_l.so !== m_lock) begin
            num_errors++; $display("FAIL so_lockup_after_negedge: got %0b expected %0b", bus_l.so, m_lock);
        end
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic pulse_reset();
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
        rst = 1'b1;
        model_reset();
        #1;
        num_checks++;
        if (bus_l.q !== RV || bus_d.q !== RV) begin
            num_errors++; $display("FAIL reset_q: got %h/%h expected %h", bus_l.q, bus_d.q, RV);
        end
        num_checks++;
        if (bus_l.so !== 1'b0 || bus_d.so !== 1'b0) begin
            num_errors++; $display("FAIL reset_so: got %0b/%0b expected 0", bus_l.so, bus_d.so);
        end
        num_checks++;
        if (bus_l.full !== 1'b0 || bus_d.full !== 1'b0) begin
            num_errors++; $display("FAIL reset_full: got %0b/%0b expected 0", bus_l.full, bus_d.full);
        end
        num_checks++;
        if (bus_l.err !== 1'b0 || bus_d.err !== 1'b0) begin
            num_errors++; $display("FAIL reset_err: got %0b/%0b expected 0", bus_l.err, bus_d.err);
        end
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
        #1;
        pulse_reset();
        // a quiet cycle after release keeps everything at reset values
        step(1'b0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic test_shift_update();
        logic [3:0] bits;
        bits = 4'b1011;
        for (int i = 3; i >= 0; i--) begin
            step(1'b1, bits[i], 1'b0, '0, 1'b0);
            num_checks++;
            if (bus_l.full !== (i == 0)) begin
                num_errors++; $display("FAIL shift_full_%0d: got %0b expected %0b", 3 - i, bus_l.full, (i == 0));
            end
        end
        num_checks++;
        if (bus_d.so !== 1'b1) begin
            num_errors++; $display("FAIL first_bit_so: got %0b expected 1", bus_d.so);
        end
        step(1'b0, 1'b0, 1'b0, '0, 1'b1);
        num_checks++;
        if (bus_l.q !== 4'b1011 || bus_l.full !== 1'b0) begin
            num_errors++; $display("FAIL update_q: got q=%h full=%0b expected q=b full=0", bus_l.q, bus_l.full);
        end
    endtask

    task automatic test_premature();
        pulse_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, 1'b0, '0, 1'b1);
        num_checks++;
        if (bus_l.q !== RV || bus_l.err !== 1'b1) begin
            num_errors++; $display("FAIL premature_upd: got q=%h err=%0b expected q=%h err=1", bus_l.q, bus_l.err, RV);
        end
        step(1'b1, 1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, 1'b0, '0, 1'b1);
        num_checks++;
        if (bus_d.q !== 4'hE || bus_d.err !== 1'b1) begin
            num_errors++; $display("FAIL err_sticky: got q=%h err=%0b expected q=e err=1", bus_d.q, bus_d.err);
        end
        pulse_reset();
    endtask

    task automatic test_capture();
        logic [3:0] pat;
        pat = 4'h6;
        step(1'b0, 1'b0, 1'b1, pat, 1'b0);
        num_checks++;
        if (bus_d.so !== pat[3] || bus_d.full !== 1'b0) begin
            num_errors++; $display("FAIL capture: got so=%0b full=%0b expected so=%0b full=0", bus_d.so, bus_d.full, pat[3]);
        end
        for (int k = 1; k <= 4; k++) begin
            step(1'b1, 1'b0, 1'b0, '0, 1'b0);
            if (k < 4) begin
                num_checks++;
                if (bus_d.so !== pat[3-k]) begin
                    num_errors++; $display("FAIL unload_bit_%0d: got %0b expected %0b", k, bus_d.so, pat[3-k]);
                end
            end
        end
        num_checks++;
        if (bus_d.full !== 1'b1) begin
            num_errors++; $display("FAIL unload_full: got %0b expected 1", bus_d.full);
        end
    endtask

    task automatic test_simultaneous();
        logic [3:0] bits;
        bits = 4'hC;
        for (int i = 3; i >= 0; i--) step(1'b1, bits[i], 1'b0, '0, 1'b0);
        step(1'b1, 1'b1, 1'b0, '0, 1'b1);
        num_checks++;
        if (bus_l.q !== 4'hC || bus_l.full !== 1'b0) begin
            num_errors++; $display("FAIL shift_and_upd: got q=%h full=%0b expected q=c full=0", bus_l.q, bus_l.full);
        end
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, '0, 1'b0);
        num_checks++;
        if (bus_l.full !== 1'b1) begin
            num_errors++; $display("FAIL recount_full: got %0b expected 1", bus_l.full);
        end
        step(1'b0, 1'b0, 1'b1, 4'h5, 1'b1);
        num_checks++;
        if (bus_d.q !== 4'hF || bus_d.full !== 1'b0 || bus_d.so !== 1'b0) begin
            num_errors++; $display("FAIL cap_and_upd: got q=%h full=%0b so=%0b expected q=f full=0 so=0", bus_d.q, bus_d.full, bus_d.so);
        end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 1'b1, 1'b0, '0, 1'b0);
        pulse_reset();
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 1'b1, 1'b0, '0, 1'b0);
            num_checks++;
            if (bus_l.full !== (i == 4)) begin
                num_errors++; $display("FAIL post_reset_full_%0d: got %0b expected %0b", i, bus_l.full, (i == 4));
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            step(($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 7) == 0),
                 W'($urandom), ($urandom_range(0, 5) == 0));
            if ($urandom_range(0, 99) == 0) pulse_reset();
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_shift_update();
        test_premature();
        test_capture();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule

// File: doc/bw_clk_cclk_scanchain_nx.md
# bw_clk_cclk_scanchain_nx

Parametrised scan chain for clock-cluster control bits. It has three parts:
- a WIDTH-bit shift chain with parallel capture;
- a guarded update register that drives configuration outputs;
- an optional falling-edge lock-up stage on the serial output.

It sits in the clock-control scan path between cluster scan segments. It replaces single-bit scan latches where a multi-bit configuration word must be loaded serially and applied atomically.

## Interface
- WIDTH, 8, chain/update register width; legal range 2..64
- RESET_VAL, 0, value of q after reset (WIDTH bits)
- LOCKUP, 1, 1: so retimed through a falling-edge lock-up stage; 0: so taken directly from the chain MSB
- ck  in  1  clock; all state updates on the rising edge except the lock-up stage
- rst  in  1  reset, asynchronous, active-high
- se  in  1  shift enable
- sd  in  1  serial scan data in
- cap  in  1  parallel capture strobe
- pd  in  WIDTH  parallel capture data
- upd  in  1  update strobe (chain -> q)
- so  out  1  serial scan data out
- q  out  WIDTH  applied configuration word
- full  out  1  exactly WIDTH bits shifted since last capture/update
- err  out  1  sticky: update requested while not full

## Operation
- State: chain[WIDTH-1:0], cnt (width $clog2(WIDTH+1)), q, err, and the lock-up register (only when LOCKUP=1).
- While rst is high, all state is held at its reset value:
  - chain=0, cnt=0, q=RESET_VAL, err=0, so=0;
  - full=0 follows from cnt=0.
- Chain update, per rising edge, in priority order:
  - se=1: chain <= {chain[WIDTH-2:0], sd}.
  - else cap=1: chain <= pd.
  - else chain holds.
- Counter, per rising edge:
  - se=1: cnt <= min(cnt+1, WIDTH). The counter saturates and does not wrap.
  - cap=1 with se=0: cnt <= 0.
- full = (cnt == WIDTH), decoded combinationally from cnt.
- Update, per rising edge, using pre-edge chain and pre-edge full:
  - upd=1 and full=1: q <= chain (pre-shift value). cnt <= 1 if se=1 in the same cycle, otherwise 0.
  - upd=1 and full=0: q holds and err <= 1.
  - err clears only on rst.
- cap and upd together with full=1: q takes the pre-capture chain; chain <= pd; cnt <= 0.
- cap has no effect on q or err.
- so:
  - LOCKUP=0: so = chain[WIDTH-1].
  - LOCKUP=1: so is a register loaded from chain[WIDTH-1] on the falling edge of ck.

## Timing
- Serial latency, sd to so:
  - LOCKUP=0: the bit appears on so WIDTH rising edges after it is sampled.
  - LOCKUP=1: the bit appears half a cycle later, at the following falling edge.
- full asserts in the same cycle as the WIDTH-th shift edge. It stays asserted while further shifting occurs, because cnt saturates.
- q changes only on a rising edge with upd=1 and full=1. It is stable through all shifting, so downstream clock logic never sees partial patterns.
- err asserts on the rising edge that samples the failing upd.
- Reset asserted mid-shift or mid-update:
  - all state, including q and the lock-up register, goes to its reset value immediately, with no clock required;
  - on deassertion, the first rising edge after rst falls is processed normally.
- Inputs are synchronous to ck. No handshake; strobes are single-cycle level samples, and holding upd high repeats the update on every qualifying edge.

## Test plan
- Reset: WIDTH=4, RESET_VAL=4'hA, assert rst with no clock -> q=4'hA, so=0, full=0, err=0.
- Shift and update: shift sd=1,0,1,1 (first bit first) -> full on the 4th edge; upd next edge -> q=4'b1011, full=0. In the same sequence check so: with LOCKUP=1 the first-shifted 1 appears on so at the falling edge after the 4th rising edge; with LOCKUP=0 it appears right after the 4th rising edge.
- Premature update: after 3 shifts, pulse upd -> q holds at 4'hA, err=1. err stays 1 through later successful updates until rst.
- Capture and unload: cap with pd=4'h6 -> cnt=0; then 4 shifts -> so emits 0,1,1,0 (MSB first); full=1 after the 4th shift.
- Simultaneous events:
  - se=1, upd=1 with full=1 and chain=4'hC -> q=4'hC, chain shifted, cnt=1;
  - cap=1, upd=1 with full=1 -> q takes the old chain and chain=pd.
- Reset mid-operation: assert rst after 2 shifts -> chain=0, cnt=0, q=RESET_VAL asynchronously. After release, 4 fresh shifts are needed before full.
